// File: rtl/dmem_arbiter_if.sv
// Signal bundle between dmem_arbiter, its two requesters (core, debug) and DataMemory.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
    parameter int BITSIZE = 32
);
    logic               c_req;
    logic               c_we;
    logic [BITSIZE-1:0] c_addr;
    logic [BITSIZE-1:0] c_wdata;
    logic [BITSIZE-1:0] c_rdata;
    logic               c_ack;
    logic               c_stall;

    logic               d_req;
    logic               d_we;
    logic [BITSIZE-1:0] d_addr;
    logic [BITSIZE-1:0] d_wdata;
    logic               d_lock;
    logic [BITSIZE-1:0] d_rdata;
    logic               d_ack;

    logic [BITSIZE-1:0] m_addr;
    logic [BITSIZE-1:0] m_wdata;
    logic               m_we;
    logic               m_re;
    logic [BITSIZE-1:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_rdata, c_ack, c_stall,
        input  d_req, d_we, d_addr, d_wdata, d_lock,
        output d_rdata, d_ack,
        output m_addr, m_wdata, m_we, m_re,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_rdata, c_ack, c_stall,
        output d_req, d_we, d_addr, d_wdata, d_lock,
        input  d_rdata, d_ack,
        input  m_addr, m_wdata, m_we, m_re,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one DataMemory between the core load/store port and the debug/loader port:
// one registered access cycle at a time, round-robin on ties, debug lock-out of the core.
module dmem_arbiter #(
    parameter int BITSIZE = 32
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } port_e;

    state_e             state_q, state_d;
    port_e              owner_q, owner_d;
    port_e              last_q, last_d;
    logic               we_q, we_d;
    logic [BITSIZE-1:0] addr_q, addr_d;
    logic [BITSIZE-1:0] wdata_q, wdata_d;
    logic [BITSIZE-1:0] c_rdata_q, c_rdata_d;
    logic [BITSIZE-1:0] d_rdata_q, d_rdata_d;
    logic               c_ack_q, c_ack_d;
    logic               d_ack_q, d_ack_d;

    logic               busy_c_s;
    logic               busy_d_s;
    logic               elig_c_s;
    logic               elig_d_s;
    logic               grant_valid_s;
    port_e              grant_s;

    // Eligibility and round-robin pick; a port already in its access cycle cannot be re-granted.
    always_comb begin
        busy_c_s      = (state_q == ST_ACCESS) && (owner_q == PORT_CORE);
        busy_d_s      = (state_q == ST_ACCESS) && (owner_q == PORT_DBG);
        elig_c_s      = bus.c_req & ~bus.d_lock & ~busy_c_s;
        elig_d_s      = bus.d_req & ~busy_d_s;
        grant_valid_s = elig_c_s | elig_d_s;
        if (elig_c_s && elig_d_s) begin
            grant_s = (last_q == PORT_CORE) ? PORT_DBG : PORT_CORE;
        end else if (elig_c_s) begin
            grant_s = PORT_CORE;
        end else begin
            grant_s = PORT_DBG;
        end
    end

    // Next-state: new grant latching plus completion of the access now on the memory bus.
    always_comb begin
        state_d   = ST_IDLE;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        c_ack_d   = 1'b0;
        d_ack_d   = 1'b0;

        if (grant_valid_s) begin
            state_d = ST_ACCESS;
            owner_d = grant_s;
            last_d  = grant_s;
            if (grant_s == PORT_CORE) begin
                we_d    = bus.c_we;
                addr_d  = bus.c_addr;
                wdata_d = bus.c_wdata;
            end else begin
                we_d    = bus.d_we;
                addr_d  = bus.d_addr;
                wdata_d = bus.d_wdata;
            end
        end else begin
            state_d = ST_IDLE;
        end

        // Read data is captured only for reads; writes leave both rdata registers alone.
        case (state_q)
            ST_ACCESS: begin
                if (owner_q == PORT_CORE) begin
                    c_ack_d = 1'b1;
                    if (!we_q) begin
                        c_rdata_d = bus.m_rdata;
                    end else begin
                        c_rdata_d = c_rdata_q;
                    end
                end else begin
                    d_ack_d = 1'b1;
                    if (!we_q) begin
                        d_rdata_d = bus.m_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end
            end
            ST_IDLE: begin
                c_ack_d = 1'b0;
                d_ack_d = 1'b0;
            end
            default: begin
                c_ack_d = 1'b0;
                d_ack_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= PORT_CORE;
            last_q    <= PORT_DBG;
            we_q      <= 1'b0;
            addr_q    <= {BITSIZE{1'b0}};
            wdata_q   <= {BITSIZE{1'b0}};
            c_rdata_q <= {BITSIZE{1'b0}};
            d_rdata_q <= {BITSIZE{1'b0}};
            c_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
            c_ack_q   <= c_ack_d;
            d_ack_q   <= d_ack_d;
        end
    end

    // Memory bus is decoded from registers; m_we is also gated by reset so the reset edge never writes.
    always_comb begin
        if (state_q == ST_ACCESS) begin
            bus.m_addr  = addr_q;
            bus.m_wdata = wdata_q;
            bus.m_we    = we_q & ~reset;
            bus.m_re    = ~we_q;
        end else begin
            bus.m_addr  = {BITSIZE{1'b0}};
            bus.m_wdata = {BITSIZE{1'b0}};
            bus.m_we    = 1'b0;
            bus.m_re    = 1'b0;
        end
    end

    // Requester-facing outputs.
    always_comb begin
        bus.c_rdata = c_rdata_q;
        bus.d_rdata = d_rdata_q;
        bus.c_ack   = c_ack_q;
        bus.d_ack   = d_ack_q;
        bus.c_stall = bus.c_req & ~c_ack_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scenarios followed by random two-port traffic checked against a transaction-level
// memory model and latency/exclusivity rules of the arbiter.
module tb_dmem_arbiter;
    localparam int W      = 32;
    localparam int MAXLAT = 3;

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic mem_init = 1'b1;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    logic [W-1:0] dmem    [0:63];
    logic [W-1:0] ref_mem [0:63];

    logic         c_pend = 1'b0, d_pend = 1'b0;
    logic         c_we_t = 1'b0, d_we_t = 1'b0;
    int           c_idx = 0, d_idx = 0, c_age = 0, d_age = 0;
    logic [W-1:0] c_wd = '0, d_wd = '0, exp_c = '0, exp_d = '0;

    dmem_arbiter_if #(.BITSIZE(W)) bus ();

    dmem_arbiter #(.BITSIZE(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // DataMemory stand-in: combinational read, write on the rising edge.
    assign bus.m_rdata = dmem[bus.m_addr[7:2]];
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'hA000_0000 + 32'(i);
        end else if (bus.m_we) begin
            dmem[bus.m_addr[7:2]] <= bus.m_wdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_c(input logic req, input logic we, input logic [W-1:0] addr, input logic [W-1:0] wd);
        bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [W-1:0] addr, input logic [W-1:0] wd);
        bus.d_req = req; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
    endtask

    // One observation step of the random phase: stall rule, exclusivity, latency, read data.
    task automatic rnd_observe();
        if (c_pend) c_age++;
        if (d_pend) d_age++;
        if (!c_pend) chk("rnd_c_stall_idle", bus.c_stall, 1'b0);
        else if (c_age < 2) chk("rnd_c_stall_wait", bus.c_stall, 1'b1);
        chk("rnd_one_ack", bus.c_ack & bus.d_ack, 1'b0);
        if (bus.c_ack) begin
            chk("rnd_c_ack_pend", c_pend, 1'b1);
            chk("rnd_c_lat", 32'(c_age <= MAXLAT), 32'd1);
            if (c_we_t) ref_mem[c_idx] = c_wd;
            else exp_c = ref_mem[c_idx];
            c_pend = 1'b0;
            set_c(1'b0, 1'b0, '0, '0);
        end else if (c_pend && c_age > MAXLAT) begin
            chk("rnd_c_timeout", 32'(c_age), 32'(MAXLAT));
            c_pend = 1'b0;
            set_c(1'b0, 1'b0, '0, '0);
        end
        if (bus.d_ack) begin
            chk("rnd_d_ack_pend", d_pend, 1'b1);
            chk("rnd_d_lat", 32'(d_age <= MAXLAT), 32'd1);
            if (d_we_t) ref_mem[d_idx] = d_wd;
            else exp_d = ref_mem[d_idx];
            d_pend = 1'b0;
            set_d(1'b0, 1'b0, '0, '0);
        end else if (d_pend && d_age > MAXLAT) begin
            chk("rnd_d_timeout", 32'(d_age), 32'(MAXLAT));
            d_pend = 1'b0;
            set_d(1'b0, 1'b0, '0, '0);
        end
        chk("rnd_c_rdata", bus.c_rdata, exp_c);
        chk("rnd_d_rdata", bus.d_rdata, exp_d);
    endtask

    initial begin
        int lat, acc, cnt_c, cnt_d;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA000_0000 + 32'(i);
        set_c(1'b1, 1'b0, '0, '0);
        set_d(1'b1, 1'b0, '0, '0);
        bus.d_lock = 1'b0;

        // Reset held two cycles with both requests high.
        for (int k = 0; k < 2; k++) begin
            tick();
            mem_init = 1'b0;
            chk("rst_c_ack", bus.c_ack, 1'b0);
            chk("rst_d_ack", bus.d_ack, 1'b0);
            chk("rst_m_we", bus.m_we, 1'b0);
            chk("rst_m_re", bus.m_re, 1'b0);
            chk("rst_c_rdata", bus.c_rdata, '0);
            chk("rst_d_rdata", bus.d_rdata, '0);
            chk("rst_c_stall", bus.c_stall, 1'b1);
        end
        reset = 1'b0;
        set_c(1'b0, 1'b0, '0, '0);
        set_d(1'b0, 1'b0, '0, '0);
        tick();

        // Debug write then core read of the same word.
        set_d(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        tick();
        chk("dw_m_we", bus.m_we, 1'b1);
        chk("dw_m_addr", bus.m_addr, 32'h10);
        chk("dw_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
        chk("dw_ack_early", bus.d_ack, 1'b0);
        tick();
        chk("dw_d_ack", bus.d_ack, 1'b1);
        chk("dw_m_we_once", bus.m_we, 1'b0);
        ref_mem[4] = 32'hDEAD_BEEF;
        set_d(1'b0, 1'b0, '0, '0);
        set_c(1'b1, 1'b0, 32'h10, '0);
        #1;
        chk("cr_stall", bus.c_stall, 1'b1);
        tick();
        chk("cr_ack_early", bus.c_ack, 1'b0);
        chk("cr_m_re", bus.m_re, 1'b1);
        tick();
        chk("cr_c_ack", bus.c_ack, 1'b1);
        chk("cr_c_rdata", bus.c_rdata, ref_mem[4]);
        chk("cr_stall_ack", bus.c_stall, 1'b0);
        set_c(1'b0, 1'b0, '0, '0);
        tick();
        chk("cr_ack_pulse", bus.c_ack, 1'b0);

        // Tie straight out of reset: core first; then a tie after a core grant goes to debug.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_c(1'b1, 1'b0, 32'h0, '0);
        set_d(1'b1, 1'b0, 32'h4, '0);
        tick();
        chk("tie1_core_first", bus.m_addr, 32'h0);
        tick();
        chk("tie1_c_ack", bus.c_ack, 1'b1);
        chk("tie1_d_noack", bus.d_ack, 1'b0);
        chk("tie1_c_rdata", bus.c_rdata, ref_mem[0]);
        chk("tie1_dbg_next", bus.m_addr, 32'h4);
        set_c(1'b0, 1'b0, '0, '0);
        tick();
        chk("tie1_d_ack", bus.d_ack, 1'b1);
        chk("tie1_c_noack", bus.c_ack, 1'b0);
        chk("tie1_d_rdata", bus.d_rdata, ref_mem[1]);
        set_d(1'b0, 1'b0, '0, '0);
        set_c(1'b1, 1'b0, 32'h8, '0);
        tick();
        tick();
        chk("solo_c_rdata", bus.c_rdata, ref_mem[2]);
        set_c(1'b1, 1'b0, 32'hC, '0);
        set_d(1'b1, 1'b0, 32'h10, '0);
        tick();
        chk("tie2_dbg_first", bus.m_addr, 32'h10);
        tick();
        chk("tie2_d_ack", bus.d_ack, 1'b1);
        chk("tie2_d_rdata", bus.d_rdata, ref_mem[4]);
        set_d(1'b0, 1'b0, '0, '0);
        tick();
        chk("tie2_c_ack", bus.c_ack, 1'b1);
        chk("tie2_c_rdata", bus.c_rdata, ref_mem[3]);
        set_c(1'b0, 1'b0, '0, '0);
        tick();

        // Both ports held for 8 grant edges: grants alternate starting with debug.
        set_c(1'b1, 1'b0, 32'h0, '0);
        set_d(1'b1, 1'b0, 32'h4, '0);
        acc = 0; cnt_c = 0; cnt_d = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k <= 8) begin
                chk("alt_grant", bus.m_addr, (k % 2 == 1) ? 32'h4 : 32'h0);
                acc += int'(bus.m_re);
            end
            if (k == 8) begin
                set_c(1'b0, 1'b0, '0, '0);
                set_d(1'b0, 1'b0, '0, '0);
            end
            chk("alt_one_ack", bus.c_ack & bus.d_ack, 1'b0);
            if (bus.c_ack) cnt_c++;
            if (bus.d_ack) cnt_d++;
        end
        chk("alt_accesses", 32'(acc), 32'd8);
        chk("alt_c_acks", 32'(cnt_c), 32'd4);
        chk("alt_d_acks", 32'(cnt_d), 32'd4);
        chk("alt_c_rdata", bus.c_rdata, ref_mem[0]);
        chk("alt_d_rdata", bus.d_rdata, ref_mem[1]);

        // Debug lock: core request held, debug writes proceed, core waits until unlock.
        bus.d_lock = 1'b1;
        set_c(1'b1, 1'b0, 32'h10, '0);
        for (int w = 0; w < 2; w++) begin
            set_d(1'b1, 1'b1, 32'h30 + 32'(4 * w), 32'h5A5A_0000 + 32'(w));
            tick();
            chk("lock_m_we", bus.m_we, 1'b1);
            chk("lock_c_noack", bus.c_ack, 1'b0);
            chk("lock_c_stall", bus.c_stall, 1'b1);
            tick();
            chk("lock_d_ack", bus.d_ack, 1'b1);
            chk("lock_c_noack2", bus.c_ack, 1'b0);
            ref_mem[12 + w] = 32'h5A5A_0000 + 32'(w);
            set_d(1'b0, 1'b0, '0, '0);
        end
        tick();
        chk("lock_no_core_grant", bus.m_re, 1'b0);
        chk("lock_c_stall_idle", bus.c_stall, 1'b1);
        bus.d_lock = 1'b0;
        lat = 0;
        while (bus.c_ack !== 1'b1 && lat < MAXLAT) begin
            tick();
            lat++;
        end
        chk("unlock_c_ack", bus.c_ack, 1'b1);
        chk("unlock_c_rdata", bus.c_rdata, ref_mem[4]);
        set_c(1'b0, 1'b0, '0, '0);
        tick();

        // Reset during a core write access: no ack and the word keeps its old value.
        set_c(1'b1, 1'b1, 32'h20, 32'h0000_1234);
        tick();
        chk("rw_m_we", bus.m_we, 1'b1);
        reset = 1'b1;
        #1;
        chk("rw_m_we_gated", bus.m_we, 1'b0);
        tick();
        chk("rw_c_noack", bus.c_ack, 1'b0);
        chk("rw_m_we_after", bus.m_we, 1'b0);
        reset = 1'b0;
        set_c(1'b0, 1'b0, '0, '0);
        tick();
        chk("rw_c_noack2", bus.c_ack, 1'b0);
        set_d(1'b1, 1'b0, 32'h20, '0);
        tick();
        tick();
        chk("rw_d_ack", bus.d_ack, 1'b1);
        chk("rw_d_rdata", bus.d_rdata, ref_mem[8]);
        set_d(1'b0, 1'b0, '0, '0);
        tick();

        // Random two-port traffic over 16 words.
        exp_c = '0;
        exp_d = ref_mem[8];
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!c_pend && $urandom_range(0, 2) != 0) begin
                c_we_t = 1'($urandom_range(0, 1));
                c_idx  = int'($urandom_range(0, 15));
                c_wd   = $urandom;
                set_c(1'b1, c_we_t, 32'(c_idx * 4), c_wd);
                c_pend = 1'b1;
                c_age  = 0;
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_we_t = 1'($urandom_range(0, 1));
                d_idx  = int'($urandom_range(0, 15));
                d_wd   = $urandom;
                set_d(1'b1, d_we_t, 32'(d_idx * 4), d_wd);
                d_pend = 1'b1;
                d_age  = 0;
            end
            tick();
            rnd_observe();
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            rnd_observe();
        end
        for (int i = 0; i < 16; i++) chk("final_mem", dmem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
